// File: rtl/jesd204_rx_err_stats_if.sv
// Error-statistics bundle between the 8b10b decoders, control regs and the CDC.
// Source side drives error/control inputs; the stats block drives the counts.
interface jesd204_rx_err_stats_if #(
    parameter int NUM_LANES       = 1,
    parameter int DATA_PATH_WIDTH = 4
);

    logic [NUM_LANES-1:0]                 core_lane_valid;
    logic [NUM_LANES*DATA_PATH_WIDTH-1:0] core_disperr;
    logic [NUM_LANES*DATA_PATH_WIDTH-1:0] core_notintable;
    logic [NUM_LANES*DATA_PATH_WIDTH-1:0] core_unexpectedk;
    logic [NUM_LANES-1:0]                 core_frame_align_err;
    logic [6:0]                           core_ctrl_err_stats_mask;
    logic                                 core_ctrl_err_stats_reset;
    logic [32*NUM_LANES-1:0]              core_err_stats_cnt;
    logic [8*NUM_LANES-1:0]               core_frame_align_err_cnt;
    logic [NUM_LANES-1:0]                 core_err_stats_sat;

    modport master (
        output core_lane_valid,
        output core_disperr,
        output core_notintable,
        output core_unexpectedk,
        output core_frame_align_err,
        output core_ctrl_err_stats_mask,
        output core_ctrl_err_stats_reset,
        input  core_err_stats_cnt,
        input  core_frame_align_err_cnt,
        input  core_err_stats_sat
    );

    modport slave (
        input  core_lane_valid,
        input  core_disperr,
        input  core_notintable,
        input  core_unexpectedk,
        input  core_frame_align_err,
        input  core_ctrl_err_stats_mask,
        input  core_ctrl_err_stats_reset,
        output core_err_stats_cnt,
        output core_frame_align_err_cnt,
        output core_err_stats_sat
    );

endinterface

// File: rtl/jesd204_rx_err_stats.sv
// Per-lane 8b10b error and frame-alignment error statistics (core clock).
// Optional sticky saturation flag: define JESD204_RX_ERR_STATS_SAT_FLAG_EN.
module jesd204_rx_err_stats #(
    parameter int NUM_LANES       = 1,
    parameter int DATA_PATH_WIDTH = 4
) (
    input logic                   core_clk,
    input logic                   core_resetn,
    jesd204_rx_err_stats_if.slave err_if
);

    localparam int OW = 3 * DATA_PATH_WIDTH;
    localparam int PW = $clog2(OW + 1);

    logic [2:0] cls_en;
    logic       stats_rst;
    logic       unused_mask;

    assign cls_en      = ~err_if.core_ctrl_err_stats_mask[2:0];
    assign stats_rst   = err_if.core_ctrl_err_stats_reset;
    assign unused_mask = ^err_if.core_ctrl_err_stats_mask[6:3];

    for (genvar l = 0; l < NUM_LANES; l++) begin : gen_lane

        logic [DATA_PATH_WIDTH-1:0] disp;
        logic [DATA_PATH_WIDTH-1:0] nit;
        logic [DATA_PATH_WIDTH-1:0] uek;
        logic [OW-1:0]              s1_d;
        logic [OW-1:0]              s1_q;
        logic [PW-1:0]              pop_d;
        logic [PW-1:0]              pop_q;
        logic [32:0]                sum;
        logic [31:0]                cnt_d;
        logic [31:0]                cnt_q;
        logic                       fa_q;
        logic [7:0]                 fac_q;

        assign disp = err_if.core_disperr[l*DATA_PATH_WIDTH +: DATA_PATH_WIDTH];
        assign nit  = err_if.core_notintable[l*DATA_PATH_WIDTH +: DATA_PATH_WIDTH];
        assign uek  = err_if.core_unexpectedk[l*DATA_PATH_WIDTH +: DATA_PATH_WIDTH];

        assign s1_d = {disp & {DATA_PATH_WIDTH{cls_en[0]}},
                       nit  & {DATA_PATH_WIDTH{cls_en[1]}},
                       uek  & {DATA_PATH_WIDTH{cls_en[2]}}}
                      & {OW{err_if.core_lane_valid[l]}};

        // Count set error bits of the registered beat.
        always_comb begin
            pop_d = '0;
            for (int i = 0; i < OW; i++) begin
                pop_d = pop_d + PW'(s1_q[i]);
            end
        end

        // 33-bit add so a carry out means the counter would wrap.
        always_comb begin
            sum   = {1'b0, cnt_q} + 33'(pop_q);
            cnt_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        end

        // Three-stage error pipeline: gate, popcount, saturating accumulate.
        always_ff @(posedge core_clk or negedge core_resetn) begin
            if (!core_resetn) begin
                s1_q  <= '0;
                pop_q <= '0;
                cnt_q <= '0;
            end else if (stats_rst) begin
                s1_q  <= '0;
                pop_q <= '0;
                cnt_q <= '0;
            end else begin
                s1_q  <= s1_d;
                pop_q <= pop_d;
                cnt_q <= cnt_d;
            end
        end

        // Frame-align pulses: register once, then saturating increment.
        always_ff @(posedge core_clk or negedge core_resetn) begin
            if (!core_resetn) begin
                fa_q  <= 1'b0;
                fac_q <= '0;
            end else if (stats_rst) begin
                fa_q  <= 1'b0;
                fac_q <= '0;
            end else begin
                fa_q <= err_if.core_frame_align_err[l];
                if (fa_q && fac_q != 8'hFF) begin
                    fac_q <= fac_q + 8'd1;
                end
            end
        end

        assign err_if.core_err_stats_cnt[32*l +: 32]      = cnt_q;
        assign err_if.core_frame_align_err_cnt[8*l +: 8] = fac_q;

`ifdef JESD204_RX_ERR_STATS_SAT_FLAG_EN
        logic sat_q;

        // Sticky flag, set on the same edge the count reaches all-ones.
        always_ff @(posedge core_clk or negedge core_resetn) begin
            if (!core_resetn) begin
                sat_q <= 1'b0;
            end else if (stats_rst) begin
                sat_q <= 1'b0;
            end else if (cnt_d == 32'hFFFF_FFFF) begin
                sat_q <= 1'b1;
            end
        end

        assign err_if.core_err_stats_sat[l] = sat_q;
`else
        assign err_if.core_err_stats_sat[l] = 1'b0;
`endif

    end

endmodule

// File: tb/tb_jesd204_rx_err_stats.sv
// Self-checking bench for jesd204_rx_err_stats (2 lanes, 4 octets per lane).
// Expected counts are queued per beat and compared when they become due.
module tb_jesd204_rx_err_stats;

    localparam int NL  = 2;
    localparam int DPW = 4;

    typedef struct {
        int          due;
        logic [31:0] c0;
        logic [31:0] c1;
    } exp_cnt_t;

    typedef struct {
        int         due;
        logic [7:0] f0;
        logic [7:0] f1;
    } exp_fac_t;

    logic core_clk    = 1'b0;
    logic core_resetn = 1'b0;

    always #5 core_clk = ~core_clk;

    jesd204_rx_err_stats_if #(
        .NUM_LANES      (NL),
        .DATA_PATH_WIDTH(DPW)
    ) err_if ();

    jesd204_rx_err_stats #(
        .NUM_LANES      (NL),
        .DATA_PATH_WIDTH(DPW)
    ) dut (
        .core_clk   (core_clk),
        .core_resetn(core_resetn),
        .err_if     (err_if)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    exp_cnt_t qe[$];
    exp_fac_t qf[$];

    logic [31:0] m_cnt [NL];
    logic [7:0]  m_fac [NL];

    always @(posedge core_clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare queued expectations on the falling edge.
    always @(negedge core_clk) begin
        exp_cnt_t e;
        exp_fac_t f;
        while (qe.size() > 0 && qe[0].due <= cyc) begin
            e = qe.pop_front();
            n_chk++;
            if (err_if.core_err_stats_cnt !== {e.c1, e.c0}) begin
                $display("FAIL sb_err_cnt cyc=%0d due=%0d got=%h exp=%h",
                         cyc, e.due, err_if.core_err_stats_cnt,
                         {e.c1, e.c0});
            end else begin
                n_pass++;
            end
        end
        while (qf.size() > 0 && qf[0].due <= cyc) begin
            f = qf.pop_front();
            n_chk++;
            if (err_if.core_frame_align_err_cnt !== {f.f1, f.f0}) begin
                $display("FAIL sb_fa_cnt cyc=%0d due=%0d got=%h exp=%h",
                         cyc, f.due, err_if.core_frame_align_err_cnt,
                         {f.f1, f.f0});
            end else begin
                n_pass++;
            end
        end
    end

    task automatic clear_model();
        qe.delete();
        qf.delete();
        for (int l = 0; l < NL; l++) begin
            m_cnt[l] = '0;
            m_fac[l] = '0;
        end
    endtask

    // Drive one beat (sampled on the next edge) and queue its expected results.
    task automatic drive(input logic [NL-1:0] v,
                         input logic [7:0] d,
                         input logic [7:0] n,
                         input logic [7:0] u,
                         input logic [NL-1:0] fa,
                         input logic [6:0] m,
                         input logic srst);
        int     c;
        int     k;
        longint t;
        err_if.core_lane_valid           = v;
        err_if.core_disperr              = d;
        err_if.core_notintable           = n;
        err_if.core_unexpectedk          = u;
        err_if.core_frame_align_err      = fa;
        err_if.core_ctrl_err_stats_mask  = m;
        err_if.core_ctrl_err_stats_reset = srst;
        c = cyc + 1;
        if (srst) begin
            while (qe.size() > 0 && qe[$].due >= c) void'(qe.pop_back());
            while (qf.size() > 0 && qf[$].due >= c) void'(qf.pop_back());
            for (int l = 0; l < NL; l++) begin
                m_cnt[l] = '0;
                m_fac[l] = '0;
            end
            qe.push_back('{due: c, c0: m_cnt[0], c1: m_cnt[1]});
            qf.push_back('{due: c, f0: m_fac[0], f1: m_fac[1]});
        end else begin
            for (int l = 0; l < NL; l++) begin
                k = 0;
                if (v[l]) begin
                    k = $countones(d[l*DPW +: DPW] & {DPW{~m[0]}})
                      + $countones(n[l*DPW +: DPW] & {DPW{~m[1]}})
                      + $countones(u[l*DPW +: DPW] & {DPW{~m[2]}});
                end
                t = longint'(m_cnt[l]) + longint'(k);
                m_cnt[l] = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
                if (fa[l] && m_fac[l] != 8'hFF) begin
                    m_fac[l] = m_fac[l] + 8'd1;
                end
            end
            qe.push_back('{due: c + 2, c0: m_cnt[0], c1: m_cnt[1]});
            qf.push_back('{due: c + 1, f0: m_fac[0], f1: m_fac[1]});
        end
        @(posedge core_clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(2'b11, 8'h00, 8'h00, 8'h00, 2'b00, 7'h00, 1'b0);
        end
    endtask

    task automatic test_reset();
        err_if.core_lane_valid           = 2'b11;
        err_if.core_disperr              = 8'hFF;
        err_if.core_notintable           = 8'hFF;
        err_if.core_unexpectedk          = 8'hFF;
        err_if.core_frame_align_err      = 2'b11;
        err_if.core_ctrl_err_stats_mask  = 7'h00;
        err_if.core_ctrl_err_stats_reset = 1'b0;
        clear_model();
        repeat (3) @(posedge core_clk);
        #1;
        n_chk++;
        if ({err_if.core_err_stats_cnt, err_if.core_frame_align_err_cnt,
             err_if.core_err_stats_sat} !== '0) begin
            $display("FAIL reset_hold got=%h/%h/%b req=0",
                     err_if.core_err_stats_cnt,
                     err_if.core_frame_align_err_cnt,
                     err_if.core_err_stats_sat);
        end else begin
            n_pass++;
        end
        core_resetn = 1'b1;
        drive(2'b11, 8'hFF, 8'hFF, 8'hFF, 2'b11, 7'h00, 1'b0);
        idle(3);
        #2;
        core_resetn = 1'b0;
        clear_model();
        #1;
        n_chk++;
        if ({err_if.core_err_stats_cnt, err_if.core_frame_align_err_cnt,
             err_if.core_err_stats_sat} !== '0) begin
            $display("FAIL reset_async got=%h/%h/%b req=0",
                     err_if.core_err_stats_cnt,
                     err_if.core_frame_align_err_cnt,
                     err_if.core_err_stats_sat);
        end else begin
            n_pass++;
        end
        err_if.core_disperr = 8'hFF;
        repeat (2) @(posedge core_clk);
        #1;
        core_resetn = 1'b1;
        idle(5);
    endtask

    task automatic test_single_beat();
        logic [31:0] o0;
        logic [31:0] o1;
        o0 = m_cnt[0];
        o1 = m_cnt[1];
        drive(2'b11, 8'h0B, 8'h01, 8'h00, 2'b00, 7'h00, 1'b0);
        idle(1);
        n_chk++;
        if (err_if.core_err_stats_cnt[31:0] !== o0) begin
            $display("FAIL beat_early got=%h req=%h",
                     err_if.core_err_stats_cnt[31:0], o0);
        end else begin
            n_pass++;
        end
        idle(1);
        n_chk++;
        if (err_if.core_err_stats_cnt !== {o1, o0 + 32'd4}) begin
            $display("FAIL beat_latency got=%h req=%h",
                     err_if.core_err_stats_cnt, {o1, o0 + 32'd4});
        end else begin
            n_pass++;
        end
        idle(2);
    endtask

    task automatic test_mask_valid();
        logic [31:0] o0;
        logic [31:0] o1;
        o0 = m_cnt[0];
        o1 = m_cnt[1];
        for (int i = 0; i < 10; i++) begin
            drive(2'b11, 8'hFF, 8'h00, 8'h00, 2'b00, 7'b0000001, 1'b0);
        end
        idle(3);
        n_chk++;
        if (err_if.core_err_stats_cnt !== {o1, o0}) begin
            $display("FAIL mask_disp got=%h req=%h",
                     err_if.core_err_stats_cnt, {o1, o0});
        end else begin
            n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 8'hFF, 8'hFF, 8'hFF, 2'b00, 7'h00, 1'b0);
        end
        idle(3);
        n_chk++;
        if (err_if.core_err_stats_cnt !== {o1, o0 + 32'd48}) begin
            $display("FAIL valid_gate got=%h req=%h",
                     err_if.core_err_stats_cnt, {o1, o0 + 32'd48});
        end else begin
            n_pass++;
        end
        drive(2'b11, 8'h00, 8'h20, 8'h00, 2'b00, 7'b0000010, 1'b0);
        drive(2'b11, 8'h00, 8'h00, 8'h40, 2'b00, 7'b0000010, 1'b0);
        idle(3);
        n_chk++;
        if (err_if.core_err_stats_cnt !== {o1 + 32'd1, o0 + 32'd48}) begin
            $display("FAIL mask_nit got=%h req=%h",
                     err_if.core_err_stats_cnt, {o1 + 32'd1, o0 + 32'd48});
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [31:0] o1;
        logic [1:0]  exp_sat;
`ifdef JESD204_RX_ERR_STATS_SAT_FLAG_EN
        exp_sat = 2'b01;
`else
        exp_sat = 2'b00;
`endif
        idle(2);
        repeat (3) @(posedge core_clk);
        #1;
        force dut.gen_lane[0].cnt_q = 32'hFFFF_FFFA;
        @(posedge core_clk);
        #1;
        release dut.gen_lane[0].cnt_q;
        m_cnt[0] = 32'hFFFF_FFFA;
        o1 = m_cnt[1];
        n_chk++;
        if (err_if.core_err_stats_sat !== 2'b00) begin
            $display("FAIL sat_pre got=%b req=00", err_if.core_err_stats_sat);
        end else begin
            n_pass++;
        end
        drive(2'b11, 8'h0F, 8'h0F, 8'h0F, 2'b00, 7'h00, 1'b0);
        idle(2);
        n_chk++;
        if (err_if.core_err_stats_cnt !== {o1, 32'hFFFF_FFFF}) begin
            $display("FAIL sat_cnt got=%h req=%h",
                     err_if.core_err_stats_cnt, {o1, 32'hFFFF_FFFF});
        end else begin
            n_pass++;
        end
        n_chk++;
        if (err_if.core_err_stats_sat !== exp_sat) begin
            $display("FAIL sat_flag got=%b req=%b",
                     err_if.core_err_stats_sat, exp_sat);
        end else begin
            n_pass++;
        end
        drive(2'b11, 8'h0F, 8'h0F, 8'h0F, 2'b00, 7'h00, 1'b0);
        idle(3);
        n_chk++;
        if (err_if.core_err_stats_cnt[31:0] !== 32'hFFFF_FFFF ||
            err_if.core_err_stats_sat !== exp_sat) begin
            $display("FAIL sat_nowrap got=%h/%b req=ffffffff/%b",
                     err_if.core_err_stats_cnt[31:0],
                     err_if.core_err_stats_sat, exp_sat);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_frame_align();
        logic [63:0] oc;
        oc = {m_cnt[1], m_cnt[0]};
        for (int i = 0; i < 300; i++) begin
            drive(2'b11, 8'h00, 8'h00, 8'h00, 2'b10, 7'h00, 1'b0);
        end
        idle(3);
        n_chk++;
        if (err_if.core_frame_align_err_cnt !== 16'hFF00) begin
            $display("FAIL fa_sat got=%h req=ff00",
                     err_if.core_frame_align_err_cnt);
        end else begin
            n_pass++;
        end
        n_chk++;
        if (err_if.core_err_stats_cnt !== oc) begin
            $display("FAIL fa_iso got=%h req=%h",
                     err_if.core_err_stats_cnt, oc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_stats_reset();
        int cf;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 8'h11, 8'h00, 8'h00, 2'b01, 7'h00, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 8'h11, 8'h00, 8'h00, 2'b01, 7'h00, 1'b1);
            n_chk++;
            if ({err_if.core_err_stats_cnt, err_if.core_frame_align_err_cnt,
                 err_if.core_err_stats_sat} !== '0) begin
                $display("FAIL srst_hold cyc=%0d got=%h/%h/%b req=0", cyc,
                         err_if.core_err_stats_cnt,
                         err_if.core_frame_align_err_cnt,
                         err_if.core_err_stats_sat);
            end else begin
                n_pass++;
            end
        end
        cf = cyc + 1;
        drive(2'b11, 8'h11, 8'h00, 8'h00, 2'b00, 7'h00, 1'b0);
        drive(2'b11, 8'h11, 8'h00, 8'h00, 2'b00, 7'h00, 1'b0);
        n_chk++;
        if (cyc != cf + 1 || err_if.core_err_stats_cnt !== 64'h0) begin
            $display("FAIL srst_first_early cyc=%0d got=%h req=0",
                     cyc, err_if.core_err_stats_cnt);
        end else begin
            n_pass++;
        end
        drive(2'b11, 8'h11, 8'h00, 8'h00, 2'b00, 7'h00, 1'b0);
        n_chk++;
        if (err_if.core_err_stats_cnt !== {32'd1, 32'd1}) begin
            $display("FAIL srst_first_inc got=%h req=%h",
                     err_if.core_err_stats_cnt, {32'd1, 32'd1});
        end else begin
            n_pass++;
        end
        idle(4);
        n_chk++;
        if (err_if.core_err_stats_cnt !== {32'd3, 32'd3} ||
            err_if.core_err_stats_sat !== 2'b00) begin
            $display("FAIL srst_resume got=%h/%b req=%h/00",
                     err_if.core_err_stats_cnt, err_if.core_err_stats_sat,
                     {32'd3, 32'd3});
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_mask_valid();
        test_saturation();
        test_frame_align();
        test_stats_reset();
        repeat (4) @(posedge core_clk);
        #1;
        n_chk++;
        if (qe.size() != 0 || qf.size() != 0) begin
            $display("FAIL sb_drain left=%0d/%0d req=0/0",
                     qe.size(), qf.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
